dma_frame_sched: RTL and testbench

DMA_FRAME_SCHED -- requirements
Module: dma_frame_sched

---
 rtl/dma_frame_sched_pkg.sv | 10 +
 rtl/dma_frame_sched_if.sv | 23 ++
 rtl/dma_frame_sched_buf_ring.sv | 19 +
 rtl/dma_frame_sched.sv | 116 +++++++++++
 tb/tb_dma_frame_sched.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/dma_frame_sched_pkg.sv
// dma_sched_pkg: state encoding and default sizing shared by the DMA frame scheduler files.
package dma_sched_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_CMD, S_XFER, S_WAIT_STS, S_DONE} sched_state_t;
    localparam int DEF_NUM_BUF = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LEN_W = 23;
    localparam int DEF_TIMEOUT_CYC = 2**24;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
    localparam logic [31:0] DEF_BUF_STRIDE = 32'h0080_0000;
endpackage

// File: rtl/dma_frame_sched_if.sv
// dma_frame_sched_if: S2MM command handshake, stream monitor and completion status of the frame DMA.
interface dma_frame_sched_if import dma_sched_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W = DEF_LEN_W
) ();
    logic cmd_valid;
    logic cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic axis_tvalid;
    logic axis_tready;
    logic axis_tlast;
    logic sts_valid;
    logic sts_err;
    modport master (
        output cmd_valid, cmd_addr, cmd_len,
        input  cmd_ready, axis_tvalid, axis_tready, axis_tlast, sts_valid, sts_err
    );
    modport slave (
        input  cmd_valid, cmd_addr, cmd_len,
        output cmd_ready, axis_tvalid, axis_tready, axis_tlast, sts_valid, sts_err
    );
endinterface

// File: rtl/dma_frame_sched_buf_ring.sv
// dma_buf_ring: frame buffer index with wrap, and the start address of the selected buffer.
module dma_buf_ring import dma_sched_pkg::*; #(
    parameter int NUM_BUF = DEF_NUM_BUF,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
    parameter logic [ADDR_W-1:0] BUF_STRIDE = ADDR_W'(DEF_BUF_STRIDE),
    localparam int IDX_W = $clog2(NUM_BUF)
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic advance,
    output logic [IDX_W-1:0] idx,
    output logic [ADDR_W-1:0] addr
);
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) idx <= '0;
        else if (advance) idx <= (idx == IDX_W'(NUM_BUF - 1)) ? '0 : idx + 1'b1;
    assign addr = BASE_ADDR + ADDR_W'(idx) * BUF_STRIDE;
endmodule

// File: rtl/dma_frame_sched.sv
// dma_frame_sched: arms one S2MM DMA transfer per camera frame into a ring of frame buffers.
// Define DMA_SCHED_WATCHDOG_EN to abort transfers stuck in XFER/WAIT_STS after TIMEOUT_CYC cycles.
module dma_frame_sched import dma_sched_pkg::*; #(
    parameter int NUM_BUF = DEF_NUM_BUF,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
    parameter logic [ADDR_W-1:0] BUF_STRIDE = ADDR_W'(DEF_BUF_STRIDE),
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic enable,
    input  logic fval,
    input  logic [LEN_W-1:0] frame_bytes,
    output logic frame_rst,
    dma_frame_sched_if.master bus,
    output logic [$clog2(NUM_BUF)-1:0] buf_idx,
    output logic frame_done,
    output logic [15:0] drop_cnt,
    output logic busy,
    output logic err,
    output logic timeout
);
    sched_state_t state;
    logic fval_q, sts_bad, wd_hit, start, drop, last_beat;
    logic [ADDR_W-1:0] ring_addr;
    assign start = fval & ~fval_q;
    assign drop = start && (state != S_IDLE || (enable && frame_bytes == '0));
    assign last_beat = bus.axis_tvalid & bus.axis_tready & bus.axis_tlast;
    assign bus.cmd_addr = ring_addr;
    dma_buf_ring #(
        .NUM_BUF(NUM_BUF), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .BUF_STRIDE(BUF_STRIDE)
    ) u_ring (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .advance(state == S_DONE && !sts_bad),
        .idx(buf_idx), .addr(ring_addr)
    );
`ifdef DMA_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;
    // Age of the current XFER or WAIT_STS visit; every exit from the state clears it.
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) wd_cnt <= '0;
        else wd_cnt <= (((state == S_XFER && !last_beat) || (state == S_WAIT_STS && !bus.sts_valid)) && !wd_hit)
                       ? wd_cnt + 1'b1 : '0;
    assign wd_hit = wd_cnt == WD_W'(TIMEOUT_CYC - 1);
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign wd_hit = 1'b0;
`endif
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            state <= S_IDLE;
            fval_q <= 1'b0;
            sts_bad <= 1'b0;
            frame_rst <= 1'b0;
            frame_done <= 1'b0;
            busy <= 1'b0;
            err <= 1'b0;
            timeout <= 1'b0;
            drop_cnt <= '0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_len <= '0;
        end else begin
            fval_q <= fval;
            frame_rst <= 1'b0;
            frame_done <= 1'b0;
            timeout <= 1'b0;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
            case (state)
                S_IDLE: if (start && enable && frame_bytes != '0) begin
                    state <= S_ARM;
                    bus.cmd_len <= frame_bytes;
                    frame_rst <= 1'b1;
                    busy <= 1'b1;
                end
                S_ARM: begin
                    state <= S_CMD;
                    bus.cmd_valid <= 1'b1;
                end
                S_CMD: if (bus.cmd_ready) begin
                    state <= S_XFER;
                    bus.cmd_valid <= 1'b0;
                end
                S_XFER: if (last_beat) state <= S_WAIT_STS;
                else if (wd_hit) begin
                    state <= S_IDLE;
                    busy <= 1'b0;
                    timeout <= 1'b1;
                    err <= 1'b1;
                end
                S_WAIT_STS: if (bus.sts_valid) begin
                    state <= S_DONE;
                    sts_bad <= bus.sts_err;
                    frame_done <= 1'b1;
                    if (bus.sts_err) err <= 1'b1;
                end else if (wd_hit) begin
                    state <= S_IDLE;
                    busy <= 1'b0;
                    timeout <= 1'b1;
                    err <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy <= 1'b0;
                    bus.cmd_valid <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_dma_frame_sched.sv
// tb_dma_frame_sched: directed self-checking bench for dma_frame_sched with default ring geometry.
module tb_dma_frame_sched;
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic enable = 1'b0;
    logic fval = 1'b0;
    logic [22:0] frame_bytes = '0;
    logic frame_rst, frame_done, busy, err, timeout;
    logic [1:0] buf_idx;
    logic [15:0] drop_cnt;
    logic done_seen;
    int checks = 0;
    int failures = 0;

    dma_frame_sched_if #(.ADDR_W(32), .LEN_W(23)) bus ();

    dma_frame_sched #(.TIMEOUT_CYC(100)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .fval(fval),
        .frame_bytes(frame_bytes), .frame_rst(frame_rst), .bus(bus), .buf_idx(buf_idx),
        .frame_done(frame_done), .drop_cnt(drop_cnt), .busy(busy), .err(err), .timeout(timeout)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full frame with cmd_ready high; se = status error, dx = extra fval rise during XFER.
    task automatic frame(input logic [22:0] bytes, input logic [31:0] addr, input logic se, input logic dx);
        fval = 1'b1;
        frame_bytes = bytes;
        tick();
        check("arm_frame_rst", frame_rst, 1);
        check("arm_busy", busy, 1);
        check("arm_cmd_valid", bus.cmd_valid, 0);
        fval = 1'b0;
        tick();
        check("cmd_valid", bus.cmd_valid, 1);
        check("cmd_addr", bus.cmd_addr, addr);
        check("cmd_len", bus.cmd_len, 32'(bytes));
        check("cmd_frame_rst", frame_rst, 0);
        tick();
        check("xfer_cmd_valid", bus.cmd_valid, 0);
        if (dx) begin
            fval = 1'b1;
            tick();
            fval = 1'b0;
        end
        bus.axis_tvalid = 1'b1;
        bus.axis_tready = 1'b1;
        bus.axis_tlast = 1'b1;
        tick();
        check("wait_done", frame_done, 0);
        bus.axis_tvalid = 1'b0;
        bus.axis_tlast = 1'b0;
        bus.sts_valid = 1'b1;
        bus.sts_err = se;
        tick();
        check("done_pulse", frame_done, 1);
        bus.sts_valid = 1'b0;
        bus.sts_err = 1'b0;
        tick();
        check("idle_busy", busy, 0);
        check("idle_done", frame_done, 0);
    endtask

    initial begin
        bus.cmd_ready = 1'b0;
        bus.axis_tvalid = 1'b0;
        bus.axis_tready = 1'b0;
        bus.axis_tlast = 1'b0;
        bus.sts_valid = 1'b0;
        bus.sts_err = 1'b0;
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_cmd_valid", bus.cmd_valid, 0);
        check("rst_cmd_addr", bus.cmd_addr, 32'h1000_0000);
        check("rst_cmd_len", bus.cmd_len, 0);
        check("rst_buf_idx", buf_idx, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_err", err, 0);
        check("rst_timeout", timeout, 0);
        check("rst_frame_rst", frame_rst, 0);
        check("rst_frame_done", frame_done, 0);
        sys_rst_n = 1'b1;
        enable = 1'b1;
        bus.cmd_ready = 1'b1;
        tick();
        frame(23'd1536, 32'h1000_0000, 1'b0, 1'b0);
        check("ring_idx1", buf_idx, 1);
        frame(23'd4096, 32'h1080_0000, 1'b0, 1'b0);
        frame(23'd64, 32'h1100_0000, 1'b0, 1'b0);
        frame(23'd100, 32'h1180_0000, 1'b0, 1'b0);
        check("ring_wrap_idx", buf_idx, 0);
        check("ring_wrap_addr", bus.cmd_addr, 32'h1000_0000);
        check("ring_err", err, 0);
        check("ring_drop", drop_cnt, 0);
        frame(23'd1536, 32'h1000_0000, 1'b1, 1'b0);
        check("sts_err_sticky", err, 1);
        check("sts_err_idx", buf_idx, 0);
        check("sts_err_addr", bus.cmd_addr, 32'h1000_0000);
        frame(23'd512, 32'h1000_0000, 1'b0, 1'b1);
        check("busy_drop", drop_cnt, 1);
        check("busy_drop_idx", buf_idx, 1);
        check("err_stays", err, 1);
        fval = 1'b1;
        frame_bytes = '0;
        tick();
        check("zero_len_busy", busy, 0);
        check("zero_len_drop", drop_cnt, 2);
        fval = 1'b0;
        tick();
        enable = 1'b0;
        fval = 1'b1;
        frame_bytes = 23'd8;
        tick();
        check("disabled_busy", busy, 0);
        check("disabled_drop", drop_cnt, 2);
        fval = 1'b0;
        tick();
        enable = 1'b1;
        bus.cmd_ready = 1'b0;
        fval = 1'b1;
        frame_bytes = 23'd256;
        tick();
        fval = 1'b0;
        enable = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", bus.cmd_valid, 1);
            check("stall_addr", bus.cmd_addr, 32'h1080_0000);
            tick();
        end
        check("stall_len", bus.cmd_len, 256);
        bus.cmd_ready = 1'b1;
        tick();
        check("no_abort_busy", busy, 1);
        check("no_abort_valid", bus.cmd_valid, 0);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", bus.cmd_valid, 0);
        check("mid_rst_idx", buf_idx, 0);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_len", bus.cmd_len, 0);
        check("mid_rst_addr", bus.cmd_addr, 32'h1000_0000);
        check("mid_rst_done", frame_done, 0);
        tick();
        sys_rst_n = 1'b1;
        bus.axis_tvalid = 1'b1;
        bus.axis_tlast = 1'b1;
        bus.sts_valid = 1'b1;
        done_seen = 1'b0;
        repeat (4) begin
            tick();
            if (frame_done) done_seen = 1'b1;
        end
        check("discarded_no_done", done_seen, 0);
        check("discarded_idle", busy, 0);
        bus.axis_tvalid = 1'b0;
        bus.axis_tlast = 1'b0;
        bus.sts_valid = 1'b0;
        enable = 1'b1;
`ifdef DMA_SCHED_WATCHDOG_EN
        fval = 1'b1;
        frame_bytes = 23'd64;
        tick();
        fval = 1'b0;
        tick();
        tick();
        repeat (99) tick();
        check("wd_before", timeout, 0);
        check("wd_before_busy", busy, 1);
        tick();
        check("wd_pulse", timeout, 1);
        check("wd_err", err, 1);
        check("wd_idle", busy, 0);
        check("wd_idx", buf_idx, 0);
        tick();
        check("wd_one_cycle", timeout, 0);
`else
        fval = 1'b1;
        frame_bytes = 23'd64;
        tick();
        fval = 1'b0;
        repeat (150) tick();
        check("no_wd_timeout", timeout, 0);
        check("no_wd_busy", busy, 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
